xlr8_i2c_target: RTL

XLR8_I2C_TARGET -- requirements
Module: xlr8_i2c_target

---
 rtl/xlr8_i2c_target.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/xlr8_i2c_target.sv
// I2C target with a 16 x 8-bit register file, a write-strobe side port and a
// combinational local read port; all bus sampling is oversampled on Clock.
module xlr8_i2c_target #(
    parameter logic [6:0]  I2C_ADDR = 7'h50,
    parameter int unsigned NREG     = 16
) (
    input  logic       Clock,
    input  logic       RESET,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_drv_low,
    output logic       busy,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        phase_q, phase_d;
    logic        rw_q, rw_d;
    logic        sda_drv_q, sda_drv_d;
    logic        busy_q, busy_d;
    logic        wr_stb_q, wr_stb_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [NREG];

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic last_bit, addr_match;
    logic [7:0] rx_byte, ptr_byte;

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise   =  scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s &  scl_prev_q;
    assign start_det  = scl_s & ~sda_s &  sda_prev_q;
    assign stop_det   = scl_s &  sda_s & ~sda_prev_q;
    assign rx_byte    = {sr_q[6:0], sda_s};
    assign last_bit   = scl_rise && (cnt_q == 3'd7);
    assign addr_match = (rx_byte[7:1] == I2C_ADDR);
    assign ptr_byte   = regs_q[ptr_q];

    assign sda_drv_low = sda_drv_q;
    assign busy        = busy_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_data     = regs_q[rd_addr];

    always_ff @(posedge Clock or posedge RESET) begin
        if (RESET) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            ptr_q      <= '0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            sda_drv_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i[3:0]] <= '0;
            end
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ptr_q      <= ptr_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            sda_drv_q  <= sda_drv_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            if (wr_stb_d) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    // ACK states: the first SCL fall starts the 9th bit, the 9th rise sets
    // phase, and the following fall leaves the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ptr_d   = ptr_q;
        phase_d = phase_q;
        rw_d    = rw_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == ADDR) begin
                                rw_d    = rx_byte[0];
                                state_d = addr_match ? ADDR_ACK : IGNORE;
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[3:0];
                                state_d = PTR_ACK;
                            end else begin
                                ptr_d   = ptr_q + 4'd1;
                                state_d = WACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WACK: begin
                    if (scl_rise) begin
                        phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        cnt_d = '0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            state_d = RDATA;
                            sr_d    = ptr_byte;
                        end else begin
                            state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ptr_d   = ptr_q + 4'd1;
                            phase_d = 1'b0;
                            state_d = RACK;
                        end
                    end else if (scl_fall) begin
                        sr_d = {sr_q[6:0], 1'b1};
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = IGNORE;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        state_d = RDATA;
                        sr_d    = ptr_byte;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_drv_d = sda_drv_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_det) begin
            sda_drv_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            sda_drv_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (last_bit && addr_match) busy_d = 1'b1;
                end
                WDATA: begin
                    if (last_bit) begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_byte;
                    end
                end
                ADDR_ACK, PTR_ACK, WACK: begin
                    if (scl_fall) begin
                        if (!phase_q)                          sda_drv_d = 1'b1;
                        else if (state_q == ADDR_ACK && rw_q)  sda_drv_d = ~ptr_byte[7];
                        else                                   sda_drv_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_fall) sda_drv_d = ~sr_q[6];
                end
                RACK: begin
                    if (scl_fall) sda_drv_d = phase_q ? ~ptr_byte[7] : 1'b0;
                end
                default: sda_drv_d = 1'b0;
            endcase
        end
    end

endmodule
